// File: rtl/microtile_pkg.sv
// Shared types and default sizing for the microtile scheduler.
package microtile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARK  = 2'd1,
        ST_RESET = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int N_TILES_DEF    = 4;
    localparam int SEL_W_DEF      = 2;
    localparam int SLICE_W_DEF    = 16;
    localparam int RST_CYCLES_DEF = 4;

endpackage

// File: rtl/microtile_sched_ctrl_if.sv
// Config handshake and tile-control bundle; the controller sits on the slave side.
// cfg is transferred on a rising clk edge where cfg_valid & cfg_ready are both high;
// cfg_valid may rise or fall at will, and cfg_ready never depends on cfg_valid.
interface microtile_sched_ctrl_if #(
    parameter int SEL_W   = 2,
    parameter int SLICE_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_en;
    logic               cfg_auto;
    logic [SEL_W-1:0]   cfg_sel;
    logic [SLICE_W-1:0] cfg_slice;
    logic [SEL_W-1:0]   sel;
    logic               tile_clk_en;
    logic               tile_rst_n;
    logic               busy;
    logic               switch_done;

    modport master (
        output cfg_valid, cfg_en, cfg_auto, cfg_sel, cfg_slice,
        input  cfg_ready, sel, tile_clk_en, tile_rst_n, busy, switch_done
    );

    modport slave (
        input  cfg_valid, cfg_en, cfg_auto, cfg_sel, cfg_slice,
        output cfg_ready, sel, tile_clk_en, tile_rst_n, busy, switch_done
    );
endinterface

// File: rtl/microtile_slice_timer.sv
// Load/decrement down-counter; o_zero flags the final cycle of a window.
module microtile_slice_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/microtile_sched_ctrl.sv
// Hands the shared pads to one microtile at a time, parking the old tile and
// resetting the new one on every ownership change (manual or round-robin).
module microtile_sched_ctrl
    import microtile_pkg::*;
#(
    parameter int N_TILES    = N_TILES_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    microtile_sched_ctrl_if.slave bus,
    output state_t                o_state
);
    localparam int                  RCNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [RCNT_W-1:0]   RCNT_ONE  = RCNT_W'(1);
    localparam logic [RCNT_W-1:0]   RCNT_LAST = RCNT_W'(RST_CYCLES - 1);
    localparam logic [SEL_W-1:0]    SEL_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(N_TILES - 1);
    localparam logic [SLICE_W-1:0]  SLICE_ONE = SLICE_W'(1);

    state_t              r_state, w_next_state;
    logic                r_en_q, r_auto_q, r_was_run;
    logic [SLICE_W-1:0]  r_slice_q;
    logic [SEL_W-1:0]    r_sel, r_next_sel;
    logic [RCNT_W-1:0]   r_rst_cnt;
    logic                w_ready, w_accept, w_expire, w_timer_zero, w_rst_last, w_run_entry;
    logic [SEL_W-1:0]    w_cfg_sel_mod, w_sel_succ;

    assign w_accept      = bus.cfg_valid & w_ready;
    assign w_rst_last    = (r_state == ST_RESET) && (r_rst_cnt == RCNT_LAST);
    assign w_run_entry   = w_rst_last;
    assign w_expire      = (r_state == ST_RUN) && w_timer_zero && r_auto_q && (r_slice_q != '0);
    assign w_cfg_sel_mod = SEL_W'(int'(bus.cfg_sel) % N_TILES);
    assign w_sel_succ    = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_ONE;
    assign o_state       = r_state;

    microtile_slice_timer #(.W(SLICE_W)) u_slice_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_run_entry),
        .i_load_val (r_slice_q - SLICE_ONE),
        .i_dec      (r_state == ST_RUN),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && bus.cfg_en) w_next_state = ST_RESET;
            ST_PARK:  w_next_state = r_en_q ? ST_RESET : ST_IDLE;
            ST_RESET: if (w_rst_last) w_next_state = ST_RUN;
            ST_RUN:   if (w_accept || w_expire) w_next_state = ST_PARK;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // An accept outranks a same-cycle slice expiry for the pending tile choice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q     <= 1'b0;
            r_auto_q   <= 1'b0;
            r_slice_q  <= '0;
            r_sel      <= '0;
            r_next_sel <= '0;
            r_rst_cnt  <= '0;
            r_was_run  <= 1'b0;
        end else begin
            r_was_run <= (r_state == ST_RUN);
            r_rst_cnt <= (r_state == ST_RESET) ? r_rst_cnt + RCNT_ONE : '0;
            if (w_accept) begin
                r_en_q     <= bus.cfg_en;
                r_auto_q   <= bus.cfg_auto;
                r_slice_q  <= bus.cfg_slice;
                r_next_sel <= w_cfg_sel_mod;
            end else if (w_expire) begin
                r_next_sel <= w_sel_succ;
            end
            if (r_state == ST_IDLE && w_next_state == ST_RESET) begin
                r_sel <= w_cfg_sel_mod;
            end else if (r_state == ST_PARK && w_next_state == ST_RESET) begin
                r_sel <= r_next_sel;
            end
        end
    end

    always_comb begin
        w_ready          = 1'b0;
        bus.tile_clk_en  = 1'b0;
        bus.tile_rst_n   = 1'b0;
        bus.busy         = 1'b0;
        bus.switch_done  = 1'b0;
        bus.sel          = r_sel;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_PARK:  bus.busy = 1'b1;
            ST_RESET: begin
                bus.busy        = 1'b1;
                bus.tile_clk_en = 1'b1;
            end
            ST_RUN: begin
                w_ready         = 1'b1;
                bus.tile_clk_en = 1'b1;
                bus.tile_rst_n  = 1'b1;
                bus.switch_done = ~r_was_run;
            end
            default: w_ready = 1'b0;
        endcase
        bus.cfg_ready = w_ready;
    end
endmodule
